// File: rtl/nanci_mesh.sv
// Nanci top-level routing fabric: SQRT_N x SQRT_N mesh that shearsorts one packet per PE by addr.
// Optional macro MESH_DEST_CHECK_EN registers a per-PE destination mismatch flag on completion.
module nanci_mesh #(
    parameter int N           = 64,
    parameter int SQRT_N      = 8,
    parameter int LOG_SQRT_N  = 3,
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 6,
    parameter int SORT_CYCLES = 53
) (
    input  logic                                    clk,
    input  logic                                    rst,
    output logic                                    done,
    output logic [N*(ADDR_WIDTH+DATA_WIDTH+1)-1:0]  result,
    output logic [N-1:0]                            err
);

    localparam int SCHED = (2*LOG_SQRT_N + 1) * SQRT_N;
    localparam int LIMIT = (SCHED > SORT_CYCLES) ? SCHED : SORT_CYCLES;
    localparam int CW    = $clog2(LIMIT + 1);
    localparam int IW    = $clog2(N);
    localparam int SW    = ADDR_WIDTH + DATA_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] addr_q [N];
    logic [ADDR_WIDTH-1:0] addr_d [N];
    logic [DATA_WIDTH-1:0] data_q [N];
    logic [DATA_WIDTH-1:0] data_d [N];
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  done_q;
    logic                  done_d;

    // Next-state: step counter and one odd-even transposition compare-exchange step.
    always_comb begin
        int                    phase;
        int                    step;
        int                    r;
        int                    c;
        int                    pos;
        int                    ppos;
        int                    pk;
        logic                  row_ph;
        logic                  asc;
        logic                  is_low;
        logic                  paired;
        logic                  swap;
        logic [ADDR_WIDTH-1:0] lo_a;
        logic [ADDR_WIDTH-1:0] hi_a;

        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        phase  = 0;
        step   = 0;
        r      = 0;
        c      = 0;
        pos    = 0;
        ppos   = 0;
        pk     = 0;
        row_ph = 1'b0;
        asc    = 1'b0;
        is_low = 1'b0;
        paired = 1'b0;
        swap   = 1'b0;
        lo_a   = '0;
        hi_a   = '0;

        if (!done_q) begin
            cnt_d  = cnt_q + CW'(1);
            done_d = (cnt_d == CW'(LIMIT));
            if (int'(cnt_q) < SCHED) begin
                phase  = int'(cnt_q) / SQRT_N;
                step   = int'(cnt_q) % SQRT_N;
                row_ph = ((phase % 2) == 0);
                for (int k = 0; k < N; k++) begin
                    r   = k / SQRT_N;
                    c   = k % SQRT_N;
                    pos = row_ph ? c : r;
                    // Row phases snake (odd rows descend) except the last, which is all ascending.
                    asc    = row_ph ? ((phase == 2*LOG_SQRT_N) || ((r % 2) == 0)) : 1'b1;
                    is_low = ((pos % 2) == (step % 2));
                    ppos   = is_low ? pos + 1 : pos - 1;
                    paired = (ppos >= 0) && (ppos < SQRT_N);
                    if (paired) begin
                        pk = row_ph ? (r*SQRT_N + ppos) : (ppos*SQRT_N + c);
                    end else begin
                        pk = k;
                    end
                    lo_a = is_low ? addr_q[k] : addr_q[IW'(pk)];
                    hi_a = is_low ? addr_q[IW'(pk)] : addr_q[k];
                    swap = asc ? (lo_a > hi_a) : (lo_a < hi_a);
                    if (paired && swap) begin
                        addr_d[k] = addr_q[IW'(pk)];
                        data_d[k] = data_q[IW'(pk)];
                    end else begin
                        addr_d[k] = addr_q[k];
                        data_d[k] = data_q[k];
                    end
                end
            end else begin
                addr_d = addr_q;
                data_d = data_q;
            end
        end else begin
            cnt_d  = cnt_q;
            done_d = 1'b1;
        end
    end

    // State registers; reset reloads the fixed application packets.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                addr_q[k] <= ADDR_WIDTH'(N - 1 - k);
                data_q[k] <= DATA_WIDTH'(k);
            end
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            for (int k = 0; k < N; k++) begin
                addr_q[k] <= addr_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    // Flat result bus: {pending, addr, data} per PE.
    always_comb begin
        result = '0;
        for (int k = 0; k < N; k++) begin
            result[k*SW +: SW] = {~done_q, addr_q[k], data_q[k]};
        end
    end

    assign done = done_q;

`ifdef MESH_DEST_CHECK_EN
    logic [N-1:0] err_q;
    logic [N-1:0] err_d;

    // Capture destination mismatches on the edge the sort completes.
    always_comb begin
        err_d = err_q;
        if (!done_q && done_d) begin
            for (int k = 0; k < N; k++) begin
                err_d[k] = (addr_d[k] != ADDR_WIDTH'(k));
            end
        end else begin
            err_d = err_q;
        end
    end

    // Mismatch flags hold until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_nanci_mesh.sv
// Bench for nanci_mesh: default 8x8 mesh plus a 2x2 instance, against a pairwise shearsort model.
module tb_nanci_mesh;

    logic         clk;
    logic         rst_a;
    logic         rst_b;
    logic         done_a;
    logic         done_b;
    logic [831:0] res_a;
    logic [19:0]  res_b;
    logic [63:0]  err_a;
    logic [3:0]   err_b;

    int total;
    int bad;

    int m_addr [64];
    int m_data [64];
    int m_cnt;
    int side;
    int lg;
    int n;
    int aw;
    int sched;
    int limit;
    int sel;

    nanci_mesh u_a (
        .clk    (clk),
        .rst    (rst_a),
        .done   (done_a),
        .result (res_a),
        .err    (err_a)
    );

    nanci_mesh #(
        .N           (4),
        .SQRT_N      (2),
        .LOG_SQRT_N  (1),
        .ADDR_WIDTH  (2),
        .DATA_WIDTH  (2),
        .SORT_CYCLES (10)
    ) u_b (
        .clk    (clk),
        .rst    (rst_b),
        .done   (done_b),
        .result (res_b),
        .err    (err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int s, input int l, input int sc);
        side  = s;
        lg    = l;
        n     = s * s;
        aw    = 2 * l;
        sched = (2*l + 1) * s;
        limit = (sched > sc) ? sched : sc;
    endtask

    task automatic model_reset();
        for (int k = 0; k < n; k++) begin
            m_addr[k] = n - 1 - k;
            m_data[k] = k;
        end
        m_cnt = 0;
    endtask

    task automatic cmpx(input int a, input int b, input bit up);
        int t;
        if (up ? (m_addr[a] > m_addr[b]) : (m_addr[a] < m_addr[b])) begin
            t = m_addr[a]; m_addr[a] = m_addr[b]; m_addr[b] = t;
            t = m_data[a]; m_data[a] = m_data[b]; m_data[b] = t;
        end
    endtask

    task automatic model_clock();
        int p;
        int s;
        if (m_cnt < limit) begin
            if (m_cnt < sched) begin
                p = m_cnt / side;
                s = m_cnt % side;
                for (int line = 0; line < side; line++) begin
                    for (int lo = s % 2; lo + 1 < side; lo += 2) begin
                        if (p % 2 == 1)
                            cmpx(lo*side + line, (lo+1)*side + line, 1'b1);
                        else
                            cmpx(line*side + lo, line*side + lo + 1,
                                 (p == 2*lg) || (line % 2 == 0));
                    end
                end
            end
            m_cnt++;
        end
    endtask

    task automatic compare();
        int          w;
        int          pend;
        logic [63:0] exp_err;
        logic [63:0] got;
        bit          mdone;
        mdone   = (m_cnt >= limit);
        pend    = mdone ? 0 : 1;
        w       = 2*aw + 1;
        exp_err = '0;
        check("done", sel ? 64'(done_b) : 64'(done_a), 64'(mdone));
        for (int k = 0; k < n; k++) begin
            got = sel ? 64'(res_b[k*5 +: 5]) : 64'(res_a[k*13 +: 13]);
            check($sformatf("slice%0d", k), got,
                  64'((pend << (2*aw)) | (m_addr[k] << aw) | m_data[k]));
`ifdef MESH_DEST_CHECK_EN
            exp_err[k] = mdone && (m_addr[k] != k);
`endif
        end
        check("err", sel ? 64'(err_b) : err_a, exp_err);
        if (w == 0) $display("unreachable");
    endtask

    task automatic step_cycle();
        logic cur;
        cur = sel ? rst_b : rst_a;
        @(posedge clk);
        #1;
        if (!cur) model_reset();
        else      model_clock();
        compare();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        sel   = 0;
        cfg(8, 3, 53);
        model_reset();

        // Reset state on the default mesh.
        repeat (2) step_cycle();

        // Full sort from reset, with phase-0 probe and exact done timing.
        rst_a = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step_cycle();
            if (i == 8) begin
                for (int c = 0; c < 8; c++) begin
                    check($sformatf("probe_r0c%0d", c), 64'(res_a[c*13 + 6 +: 6]), 64'(56 + c));
                    check($sformatf("probe_r1c%0d", c), 64'(res_a[(8+c)*13 + 6 +: 6]), 64'(55 - c));
                end
            end
            if (i == 55) check("done_at55", 64'(done_a), 64'(0));
            if (i == 56) check("done_at56", 64'(done_a), 64'(1));
        end
        for (int k = 0; k < 64; k++)
            check($sformatf("final%0d", k), 64'(res_a[k*13 +: 13]),
                  64'((k << 6) | (63 - k)));
        check("err_final", err_a, 64'(0));

        // Mid-sort reset aborts and restarts.
        rst_a = 1'b0;
        step_cycle();
        rst_a = 1'b1;
        repeat (20) step_cycle();
        rst_a = 1'b0;
        step_cycle();
        rst_a = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            step_cycle();
            if (i == 55) check("re_done55", 64'(done_a), 64'(0));
            if (i == 56) check("re_done56", 64'(done_a), 64'(1));
        end
        for (int k = 0; k < 64; k++)
            check($sformatf("re_final%0d", k), 64'(res_a[k*13 +: 13]),
                  64'((k << 6) | (63 - k)));

        // Randomly timed resets against the model.
        for (int i = 0; i < 600; i++) begin
            rst_a = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            step_cycle();
        end

        // Small mesh held in reset the whole time: static initial packets.
        check("b_hold_done", 64'(done_b), 64'(0));
        check("b_hold_err", 64'(err_b), 64'(0));
        for (int k = 0; k < 4; k++)
            check($sformatf("b_hold%0d", k), 64'(res_b[k*5 +: 5]),
                  64'((1 << 4) | ((3 - k) << 2) | k));

        // Small mesh: SORT_CYCLES dominates the schedule.
        sel = 1;
        cfg(2, 1, 10);
        model_reset();
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) rst_b = 1'b1;
            step_cycle();
            if (i == 9)  check("b_done9", 64'(done_b), 64'(0));
            if (i == 10) check("b_done10", 64'(done_b), 64'(1));
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("b_final%0d", k), 64'(res_b[k*5 +: 5]),
                  64'((k << 2) | (3 - k)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
